friscv_mem_router_n: RTL and testbench
======================================

// Module: friscv_mem_router_n
// PURPOSE
//  Registered N-way memory router for the data path. It sits between the core's load/store unit and SLV_NB slaves (GPIO, data RAM, timers, ...).
//  Decodes each master request against per-slave base/size windows and forwards it with a slave-local offset address.
//  Returns the slave's read data, or a decode-error response for unmapped addresses.
// PARAMETERS
//  ADDRW     16                     address width
//  XLEN      32                     data width; strobe width is XLEN/8
//  SLV_NB    2                      number of slaves, 1..8
//  SLV_BASE  {16'd2048,16'd0}       packed SLV_NB*ADDRW; slice i is the base of slave i
//  SLV_SIZE  {16'd16384,16'd2048}   packed SLV_NB*ADDRW; slice i is the window size of slave i (non-zero)
//  TIMEOUT   255                    watchdog limit in cycles; used only with FRISCV_ROUTER_TIMEOUT_EN
// PORTS
//  aclk       in   1            clock
//  aresetn    in   1            asynchronous active-low reset
//  mst_en     in   1            request valid; held stable until mst_ready
//  mst_wr     in   1            1 = write, 0 = read
//  mst_addr   in   ADDRW        byte address
//  mst_wdata  in   XLEN         write data
//  mst_strb   in   XLEN/8       write byte strobes
//  mst_rdata  out  XLEN         read data; valid while mst_ready=1
//  mst_ready  out  1            one-cycle completion pulse
//  mst_err    out  1            decode error or timeout; valid while mst_ready=1
//  slv_en     out  SLV_NB       one-hot request to the selected slave
//  slv_wr     out  1            shared, qualified by slv_en
//  slv_addr   out  ADDRW        shared; equals mst_addr - SLV_BASE[sel]
//  slv_wdata  out  XLEN         shared
//  slv_strb   out  XLEN/8       shared
//  slv_rdata  in   SLV_NB*XLEN  read data from each slave
//  slv_ready  in   SLV_NB       slave i completes in the cycle slv_en[i] & slv_ready[i]
// BEHAVIOUR
//  Reset: all outputs 0 and FSM in IDLE. Reset is asynchronous; mid-transaction it drops slv_en at once and no response is delivered.
//  Decode: slave i hits when SLV_BASE[i] <= addr < SLV_BASE[i]+SLV_SIZE[i]. The sum is computed on ADDRW+1 bits, so there is no wrap.
//    Overlapping windows: the lowest index wins.
//  FSM states:
//    IDLE: when mst_en=1, register wr/addr-offset/wdata/strb/sel. On a hit go to BUSY; on a miss go to ERR.
//    BUSY: slv_en[sel]=1 (registered). On slv_ready[sel], capture slv_rdata[sel], drop slv_en and go to RESP.
//    RESP: mst_ready=1, mst_err=0, mst_rdata=captured data; next state IDLE.
//    ERR: mst_ready=1, mst_err=1, mst_rdata=0; next state IDLE.
//  Latency: hit with zero-wait slave = 3 cycles from mst_en to mst_ready; each slave wait state adds 1. Miss = 2 cycles.
//  mst_rdata is 0 whenever mst_ready=0. Writes also return rdata=0.
//  IDLE does not sample mst_en during the RESP/ERR cycle. A new request is accepted the cycle after the mst_ready pulse.
//    The master must drop or change mst_en in the cycle after mst_ready.
//  slv_ready from non-selected slaves is ignored. slv_ready[sel] arriving in the same cycle as the BUSY entry edge is not possible (slv_en is registered).
//  No further request is accepted while BUSY. Exactly one transaction is outstanding at a time.
// CONFIGURATION
//  FRISCV_ROUTER_TIMEOUT_EN defined:
//    An 8..16-bit counter clears on BUSY entry and increments each BUSY cycle.
//    When it reaches TIMEOUT: drop slv_en, go to ERR (mst_err=1). A late slv_ready is ignored.
//  Not defined: no counter, and BUSY waits forever for slv_ready.
// STRUCTURE
//  friscv_h.sv gains a router FSM state typedef (IDLE/BUSY/RESP/ERR) and a router decode-error constant.
//  Sub-module friscv_router_decoder: combinational; inputs addr; outputs hit, sel index and local offset.
//  Top module: registers, FSM, optional watchdog, response muxing.
// TESTING
//  1. Read 0x0804, slave1 ready after 0 waits -> slv_en=2'b10, slv_addr=0x0004; mst_ready at cycle 3 with slv_rdata[1].
//  2. Write 0x0010, strb=4'b0011, slave0 3 waits -> slv_wr=1, slv_strb=0011; mst_ready at cycle 6, mst_err=0.
//  3. Read 0x9000 (unmapped) -> no slv_en; mst_ready at cycle 2 with mst_err=1 and rdata=0.
//  4. Back-to-back reads 0x0000 then 0x0800 -> two completions with no lost request; exactly one slv_en bit high at any time.
//  5. aresetn low during BUSY -> slv_en=0 immediately; no mst_ready; next request after reset completes normally.
//  6. Macro defined, TIMEOUT=4, slave never ready -> mst_err=1 after 4 BUSY cycles; a later slv_ready is ignored.

Source files
------------

// File: rtl/friscv_mem_router_n_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : friscv_mem_router_n_pkg                                      |
// | Description : Shared types, constants and sizing helpers for the N-way     |
// |               data-path memory router.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package friscv_mem_router_n_pkg;

   // Router FSM states
   typedef enum logic [1:0] {
      RT_IDLE = 2'd0,
      RT_BUSY = 2'd1,
      RT_RESP = 2'd2,
      RT_ERR  = 2'd3
   } router_state_t;

   // Value returned on mst_err for an address that maps to no slave
   localparam logic ROUTER_DECODE_ERR = 1'b1;

   // Watchdog counter width is kept between these bounds
   localparam int WDOG_MIN_W = 8;
   localparam int WDOG_MAX_W = 16;

   // Width of a slave index; a single-slave router still carries one bit
   function automatic int sel_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   // Width of the watchdog counter able to reach the given limit
   function automatic int wdog_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      if (w < WDOG_MIN_W) w = WDOG_MIN_W;
      if (w > WDOG_MAX_W) w = WDOG_MAX_W;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/friscv_mem_router_n_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : friscv_mem_router_n_decoder                                  |
// | Description : Combinational address decoder. Compares the address against  |
// |               every slave window and returns hit, slave index and the      |
// |               slave-local offset. Lowest index wins on overlap.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module friscv_mem_router_n_decoder
   import friscv_mem_router_n_pkg::*;
#(
   parameter int                       ADDRW    = 16,
   parameter int                       SLV_NB   = 2,
   parameter logic [SLV_NB*ADDRW-1:0]  SLV_BASE = {16'd2048, 16'd0},
   parameter logic [SLV_NB*ADDRW-1:0]  SLV_SIZE = {16'd16384, 16'd2048},
   parameter int                       SELW     = sel_width(SLV_NB)
)(
   input  logic [ADDRW-1:0] addr,
   output logic             hit,
   output logic [SELW-1:0]  sel,
   output logic [ADDRW-1:0] offset
);

   logic [SLV_NB-1:0] win_hit;

   // Window compare per slave; the upper bound is one bit wider so a window
   // touching the top of the address space cannot wrap to zero.
   generate
      for (genvar i = 0; i < SLV_NB; i++) begin : g_win
         logic [ADDRW:0] lo;
         logic [ADDRW:0] hi;
         assign lo         = {1'b0, SLV_BASE[i*ADDRW +: ADDRW]};
         assign hi         = lo + {1'b0, SLV_SIZE[i*ADDRW +: ADDRW]};
         assign win_hit[i] = ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
      end
   endgenerate

   // Priority select: scan from the highest index down so the lowest hit wins
   always_comb begin
      hit    = 1'b0;
      sel    = '0;
      offset = addr;
      for (int i = SLV_NB - 1; i >= 0; i--) begin
         if (win_hit[i]) begin
            hit    = 1'b1;
            sel    = SELW'(i);
            offset = addr - SLV_BASE[i*ADDRW +: ADDRW];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/friscv_mem_router_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : friscv_mem_router_n                                          |
// | Description : Registered N-way memory router between the load/store unit   |
// |               and SLV_NB slaves. One transaction outstanding at a time;    |
// |               unmapped addresses return a decode error.                    |
// | Options     : FRISCV_ROUTER_TIMEOUT_EN - BUSY watchdog, aborts to an error |
// |               response after TIMEOUT cycles without slave completion.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module friscv_mem_router_n
   import friscv_mem_router_n_pkg::*;
#(
   parameter int                       ADDRW    = 16,
   parameter int                       XLEN     = 32,
   parameter int                       SLV_NB   = 2,
   parameter logic [SLV_NB*ADDRW-1:0]  SLV_BASE = {16'd2048, 16'd0},
   parameter logic [SLV_NB*ADDRW-1:0]  SLV_SIZE = {16'd16384, 16'd2048},
   parameter int                       TIMEOUT  = 255
)(
   input  logic                     aclk,
   input  logic                     aresetn,
   // master side
   input  logic                     mst_en,
   input  logic                     mst_wr,
   input  logic [ADDRW-1:0]         mst_addr,
   input  logic [XLEN-1:0]          mst_wdata,
   input  logic [XLEN/8-1:0]        mst_strb,
   output logic [XLEN-1:0]          mst_rdata,
   output logic                     mst_ready,
   output logic                     mst_err,
   // slave side
   output logic [SLV_NB-1:0]        slv_en,
   output logic                     slv_wr,
   output logic [ADDRW-1:0]         slv_addr,
   output logic [XLEN-1:0]          slv_wdata,
   output logic [XLEN/8-1:0]        slv_strb,
   input  logic [SLV_NB*XLEN-1:0]   slv_rdata,
   input  logic [SLV_NB-1:0]        slv_ready
);

   localparam int SELW = sel_width(SLV_NB);

   router_state_t      state;
   logic [SELW-1:0]    sel;

   logic               dec_hit;
   logic [SELW-1:0]    dec_sel;
   logic [ADDRW-1:0]   dec_offset;
   logic [SLV_NB-1:0]  dec_onehot;

   logic               sel_ready;
   logic [XLEN-1:0]    sel_rdata;
   logic               wdog_expired;

   friscv_mem_router_n_decoder #(
      .ADDRW    (ADDRW),
      .SLV_NB   (SLV_NB),
      .SLV_BASE (SLV_BASE),
      .SLV_SIZE (SLV_SIZE),
      .SELW     (SELW)
   ) u_decoder (
      .addr     (mst_addr),
      .hit      (dec_hit),
      .sel      (dec_sel),
      .offset   (dec_offset)
   );

   // One-hot enable pattern for the decoded slave index
   always_comb begin
      dec_onehot = '0;
      for (int i = 0; i < SLV_NB; i++) begin
         if (dec_sel == SELW'(i)) dec_onehot[i] = 1'b1;
      end
   end

   // Pick the handshake and read data of the registered slave only;
   // ready from any other slave is ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < SLV_NB; i++) begin
         if (sel == SELW'(i)) begin
            sel_ready = slv_ready[i];
            sel_rdata = slv_rdata[i*XLEN +: XLEN];
         end
      end
   end

`ifdef FRISCV_ROUTER_TIMEOUT_EN
   localparam int                WDOG_W    = wdog_width(TIMEOUT);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   logic [WDOG_W-1:0] wdog_cnt;

   // Watchdog: counts BUSY cycles, restarts whenever the router is not BUSY
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                wdog_cnt <= '0;
      else if (state != RT_BUSY)   wdog_cnt <= '0;
      else                         wdog_cnt <= wdog_cnt + WDOG_W'(1);
   end

   // The last BUSY cycle of the allowed window: without ready we abort
   assign wdog_expired = (wdog_cnt == WDOG_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign wdog_expired   = 1'b0;
`endif

   // Router FSM: accept request, run the slave handshake, deliver one response pulse
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= RT_IDLE;
         sel       <= '0;
         slv_en    <= '0;
         slv_wr    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         slv_strb  <= '0;
         mst_ready <= 1'b0;
         mst_err   <= 1'b0;
         mst_rdata <= '0;
      end else begin
         case (state)
            RT_IDLE: begin
               mst_ready <= 1'b0;
               mst_err   <= 1'b0;
               mst_rdata <= '0;
               if (mst_en) begin
                  slv_wr    <= mst_wr;
                  slv_addr  <= dec_offset;
                  slv_wdata <= mst_wdata;
                  slv_strb  <= mst_strb;
                  sel       <= dec_sel;
                  if (dec_hit) begin
                     slv_en <= dec_onehot;
                     state  <= RT_BUSY;
                  end else begin
                     mst_ready <= 1'b1;
                     mst_err   <= ROUTER_DECODE_ERR;
                     state     <= RT_ERR;
                  end
               end
            end
            RT_BUSY: begin
               // Slave completion takes priority over a watchdog expiring in the same cycle
               if (sel_ready) begin
                  slv_en    <= '0;
                  mst_ready <= 1'b1;
                  mst_err   <= 1'b0;
                  mst_rdata <= slv_wr ? '0 : sel_rdata;
                  state     <= RT_RESP;
               end else if (wdog_expired) begin
                  slv_en    <= '0;
                  mst_ready <= 1'b1;
                  mst_err   <= 1'b1;
                  mst_rdata <= '0;
                  state     <= RT_ERR;
               end
            end
            RT_RESP, RT_ERR: begin
               // Response pulse lasts exactly one cycle; mst_en is not sampled here
               mst_ready <= 1'b0;
               mst_err   <= 1'b0;
               mst_rdata <= '0;
               state     <= RT_IDLE;
            end
            default: state <= RT_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_friscv_mem_router_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_friscv_mem_router_n                                       |
// | Description : Self-checking bench for friscv_mem_router_n. Each request    |
// |               is turned into a per-cycle expected output timeline from the |
// |               address map and latency rules; one process compares it.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_friscv_mem_router_n;

   localparam int T_OUT = 4;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          mst_en;
   logic          mst_wr;
   logic [15:0]   mst_addr;
   logic [31:0]   mst_wdata;
   logic [3:0]    mst_strb;
   logic [31:0]   mst_rdata;
   logic          mst_ready;
   logic          mst_err;
   logic [1:0]    slv_en;
   logic          slv_wr;
   logic [15:0]   slv_addr;
   logic [31:0]   slv_wdata;
   logic [3:0]    slv_strb;
   logic [63:0]   slv_rdata;
   logic [1:0]    slv_ready;

   friscv_mem_router_n #(
      .ADDRW    (16),
      .XLEN     (32),
      .SLV_NB   (2),
      .SLV_BASE ({16'd2048, 16'd0}),
      .SLV_SIZE ({16'd16384, 16'd2048}),
      .TIMEOUT  (T_OUT)
   ) dut (
      .aclk      (clk),
      .aresetn   (aresetn),
      .mst_en    (mst_en),
      .mst_wr    (mst_wr),
      .mst_addr  (mst_addr),
      .mst_wdata (mst_wdata),
      .mst_strb  (mst_strb),
      .mst_rdata (mst_rdata),
      .mst_ready (mst_ready),
      .mst_err   (mst_err),
      .slv_en    (slv_en),
      .slv_wr    (slv_wr),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_strb  (slv_strb),
      .slv_rdata (slv_rdata),
      .slv_ready (slv_ready)
   );

   always #5 clk = ~clk;

   // Expected outputs for one sampled cycle
   typedef struct packed {
      logic [1:0]  en;
      logic [15:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        rdy;
      logic        err;
      logic [31:0] rdata;
   } rec_t;

   rec_t   exp_q[$];
   rec_t   cur;
   rec_t   idle_rec;
   bit     chk_on = 1'b0;
   int     vectors = 0;
   int     miscompares = 0;

   // Address map of the device under test, written from the plain numbers
   int          m_base [2] = '{0, 2048};
   int          m_size [2] = '{2048, 16384};
   logic [15:0] bnd    [6] = '{16'h0000, 16'h07FF, 16'h0800, 16'h47FF, 16'h4800, 16'hFFFF};

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Reference decode: first window (lowest index) containing the address
   function automatic void decode(input int a, output bit hit, output int idx, output int off);
      hit = 1'b0; idx = 0; off = a;
      for (int i = 0; i < 2; i++) begin
         if (!hit && a >= m_base[i] && a < m_base[i] + m_size[i]) begin
            hit = 1'b1; idx = i; off = a - m_base[i];
         end
      end
   endfunction

   // Compare process: one expected record per falling edge, idle when none queued
   always @(negedge clk) begin
      if (chk_on) begin
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else                  cur = idle_rec;
         chk("slv_en",    slv_en,    cur.en);
         chk("mst_ready", mst_ready, cur.rdy);
         chk("mst_err",   mst_err,   cur.err);
         chk("mst_rdata", mst_rdata, cur.rdata);
         if (cur.en != 2'b00) begin
            chk("slv_addr",  slv_addr,  cur.addr);
            chk("slv_wr",    slv_wr,    cur.wr);
            chk("slv_wdata", slv_wdata, cur.wdata);
            chk("slv_strb",  slv_strb,  cur.strb);
         end
      end
   end

   // One complete transaction: builds the expected timeline and plays the slave
   task automatic run_txn(input logic [15:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] st, input int waits, input logic [31:0] rd);
      bit   hit;
      bit   tmo;
      int   idx, off, busy_n, nrec, cycles;
      rec_t r;
      decode(int'(a), hit, idx, off);
      tmo    = 1'b0;
      busy_n = waits + 1;
`ifdef FRISCV_ROUTER_TIMEOUT_EN
      if (hit && waits + 1 > T_OUT) begin
         tmo    = 1'b1;
         busy_n = T_OUT;
      end
`endif
      mst_en = 1'b1; mst_wr = w; mst_addr = a; mst_wdata = wd; mst_strb = st;
      exp_q.push_back(idle_rec);
      if (hit) begin
         r = idle_rec;
         r.en = 2'(1 << idx); r.addr = 16'(off); r.wr = w; r.wdata = wd; r.strb = st;
         for (int c = 0; c < busy_n; c++) exp_q.push_back(r);
         r = idle_rec;
         r.rdy = 1'b1; r.err = tmo; r.rdata = (w || tmo) ? 32'h0 : rd;
         exp_q.push_back(r);
         nrec = busy_n + 2;
      end else begin
         r = idle_rec;
         r.rdy = 1'b1; r.err = 1'b1;
         exp_q.push_back(r);
         nrec = 2;
      end
      cycles = nrec;
      if (hit && waits + 2 > cycles) begin
         for (int c = cycles; c < waits + 2; c++) exp_q.push_back(idle_rec);
         cycles = waits + 2;
      end
      for (int c = 1; c <= cycles; c++) begin
         @(posedge clk); #1;
         slv_rdata = {$urandom, $urandom};
         slv_ready = 2'($urandom);
         if (hit) begin
            slv_ready[idx] = (c == waits + 1);
            if (c == waits + 1) slv_rdata[idx*32 +: 32] = rd;
         end
         if (c >= nrec) mst_en = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(idle_rec);
         @(posedge clk); #1;
         slv_ready = 2'($urandom);
         slv_rdata = {$urandom, $urandom};
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      int          k;
      idle_rec  = '0;
      aresetn   = 1'b1;
      mst_en    = 1'b0; mst_wr = 1'b0; mst_addr = '0; mst_wdata = '0; mst_strb = '0;
      slv_rdata = '0;   slv_ready = '0;
      #1 aresetn = 1'b0;
      #1;
      chk("rst_slv_en",    slv_en,    2'b00);
      chk("rst_mst_ready", mst_ready, 1'b0);
      chk("rst_mst_err",   mst_err,   1'b0);
      chk("rst_mst_rdata", mst_rdata, 32'h0);
      chk("rst_slv_addr",  slv_addr,  16'h0);
      repeat (3) @(posedge clk);
      #1 aresetn = 1'b1;
      @(posedge clk); #1;
      chk_on = 1'b1;

      // Read 0x0804 from slave 1, zero wait states
      fork
         run_txn(16'h0804, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_0001);
         begin
            @(negedge clk); @(negedge clk);
            chk("t1_slv_en",   slv_en,   2'b10);
            chk("t1_slv_addr", slv_addr, 16'h0004);
            @(negedge clk);
            chk("t1_ready", mst_ready, 1'b1);
            chk("t1_rdata", mst_rdata, 32'hCAFE_0001);
         end
      join

      // Write 0x0010 to slave 0, three wait states
      fork
         run_txn(16'h0010, 1'b1, 32'h1234_5678, 4'b0011, 3, 32'hDEAD_BEEF);
         begin
            @(negedge clk); @(negedge clk);
            chk("t2_slv_en",   slv_en,   2'b01);
            chk("t2_slv_wr",   slv_wr,   1'b1);
            chk("t2_slv_strb", slv_strb, 4'b0011);
            repeat (4) @(negedge clk);
            chk("t2_ready", mst_ready, 1'b1);
            chk("t2_err",   mst_err,   1'b0);
            chk("t2_rdata", mst_rdata, 32'h0);
         end
      join

      // Unmapped read 0x9000
      fork
         run_txn(16'h9000, 1'b0, 32'h0, 4'hF, 0, 32'h5555_AAAA);
         begin
            @(negedge clk); @(negedge clk);
            chk("t3_slv_en", slv_en,    2'b00);
            chk("t3_ready",  mst_ready, 1'b1);
            chk("t3_err",    mst_err,   1'b1);
            chk("t3_rdata",  mst_rdata, 32'h0);
         end
      join

      // Back-to-back reads and window boundaries
      run_txn(16'h0000, 1'b0, 32'h0, 4'hF, 1, 32'h0000_1111);
      run_txn(16'h0800, 1'b0, 32'h0, 4'hF, 0, 32'h0000_2222);
      run_txn(16'h07FF, 1'b0, 32'h0, 4'hF, 2, 32'h0000_3333);
      run_txn(16'h47FF, 1'b0, 32'h0, 4'hF, 0, 32'h0000_4444);
      run_txn(16'h4800, 1'b0, 32'h0, 4'hF, 0, 32'h0000_5555);

      // Asynchronous reset while BUSY
      chk_on = 1'b0;
      mst_en = 1'b1; mst_wr = 1'b0; mst_addr = 16'h0010; slv_ready = 2'b00;
      @(posedge clk); #1;
      slv_ready = 2'b00;
      @(posedge clk); #1;
      chk("t5_busy_en", slv_en, 2'b01);
      #2 aresetn = 1'b0;
      #1;
      chk("t5_rst_en",    slv_en,    2'b00);
      chk("t5_rst_ready", mst_ready, 1'b0);
      mst_en    = 1'b0;
      slv_ready = 2'b01;
      repeat (2) begin
         @(negedge clk);
         chk("t5_no_resp", mst_ready, 1'b0);
         chk("t5_no_en",   slv_en,    2'b00);
      end
      @(posedge clk); #1;
      aresetn   = 1'b1;
      slv_ready = 2'b00;
      @(posedge clk); #1;
      chk_on = 1'b1;
      run_txn(16'h0010, 1'b0, 32'h0, 4'hF, 1, 32'h0BAD_F00D);

`ifdef FRISCV_ROUTER_TIMEOUT_EN
      // Slave never answers in time; its late ready must be ignored
      fork
         run_txn(16'h0804, 1'b0, 32'h0, 4'hF, 9, 32'h7777_7777);
         begin
            repeat (T_OUT + 1) @(negedge clk);
            chk("t6_busy_en", slv_en, 2'b10);
            @(negedge clk);
            chk("t6_ready", mst_ready, 1'b1);
            chk("t6_err",   mst_err,   1'b1);
            chk("t6_en",    slv_en,    2'b00);
         end
      join
`endif

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 3);
         case (k)
            0:       a = 16'($urandom_range(0, 16'h07FF));
            1:       a = 16'($urandom_range(16'h0800, 16'h47FF));
            2:       a = bnd[$urandom_range(0, 5)];
            default: a = 16'($urandom);
         endcase
         run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end

      idle_cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
